// File: rtl/step_pkg.sv
// Shared types and constants for the pedometer session controller.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DISP_TOTAL  = 2'd0,
    DISP_DIST   = 2'd1,
    DISP_ACTIVE = 2'd2,
    DISP_RATE   = 2'd3
  } disp_e;

  localparam int unsigned STEPS_PER_HALF_MILE_SHIFT = 10;

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchronizer plus one history flop; emits a one-cycle pulse per rising edge.
module step_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/step_session_ctrl.sv
// Pedometer session controller: step capture, IDLE/RUN/PAUSE sequencing, statistics, display.
// Optional sticky overflow output when STEP_OVERFLOW_FLAG_EN is defined.
module step_session_ctrl
  import step_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned MAX_STEPS   = 9999,
  parameter int unsigned RATE_THRESH = 32,
  parameter int unsigned DISP_SECS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        step_raw,
  output logic [15:0] step_total,
  output logic [7:0]  step_rate,
  output logic [7:0]  distance_half,
  output logic [15:0] active_secs,
  output logic [1:0]  disp_sel,
`ifdef STEP_OVERFLOW_FLAG_EN
  output logic        overflow,
`endif
  output logic [1:0]  state
);

  localparam int unsigned TickW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DispW = (DISP_SECS > 1) ? $clog2(DISP_SECS) : 1;

  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [DispW-1:0]  disp_cnt_q, disp_cnt_d;
  logic [15:0]       total_q, total_d;
  logic [15:0]       active_q, active_d;
  logic [7:0]        win_q, win_d;
  logic [7:0]        rate_q, rate_d;
  logic [1:0]        disp_sel_q, disp_sel_d;
  logic              step_evt, run, tick, evt, at_max;
  logic [7:0]        win_inc, rate_cap;

  step_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (step_raw),
    .rise_pulse (step_evt)
  );

  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (pause) state_d = PAUSE;
        PAUSE:   if (!pause) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign run      = (state_q == RUN);
  assign tick     = run && (tick_q == TickW'(CLK_HZ - 1));
  assign evt      = run && step_evt;
  assign at_max   = (total_q == 16'(MAX_STEPS));
  assign win_inc  = (win_q == 8'hFF) ? win_q : win_q + 8'd1;
  // A step landing on the tick cycle belongs to the window being closed.
  assign rate_cap = evt ? win_inc : win_q;

  always_comb begin
    tick_d     = tick_q;
    disp_cnt_d = disp_cnt_q;
    total_d    = total_q;
    active_d   = active_q;
    win_d      = win_q;
    rate_d     = rate_q;
    disp_sel_d = disp_sel_q;
    if (state_q == IDLE) begin
      tick_d     = '0;
      disp_cnt_d = '0;
      total_d    = '0;
      active_d   = '0;
      win_d      = '0;
      rate_d     = '0;
      disp_sel_d = DISP_TOTAL;
    end else if (run) begin
      tick_d = tick ? '0 : tick_q + TickW'(1);
      if (evt) begin
        if (!at_max) total_d = total_q + 16'd1;
        win_d = win_inc;
      end
      if (tick) begin
        rate_d = rate_cap;
        win_d  = '0;
        if (({24'd0, rate_cap} >= RATE_THRESH) && (active_q != 16'hFFFF)) begin
          active_d = active_q + 16'd1;
        end
        if (disp_cnt_q == DispW'(DISP_SECS - 1)) begin
          disp_cnt_d = '0;
          disp_sel_d = disp_sel_q + 2'd1;
        end else begin
          disp_cnt_d = disp_cnt_q + DispW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q     <= '0;
      disp_cnt_q <= '0;
      total_q    <= '0;
      active_q   <= '0;
      win_q      <= '0;
      rate_q     <= '0;
      disp_sel_q <= '0;
    end else begin
      tick_q     <= tick_d;
      disp_cnt_q <= disp_cnt_d;
      total_q    <= total_d;
      active_q   <= active_d;
      win_q      <= win_d;
      rate_q     <= rate_d;
      disp_sel_q <= disp_sel_d;
    end
  end

`ifdef STEP_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      ovf_d = 1'b0;
    end else if (evt && at_max) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  assign step_total    = total_q;
  assign step_rate     = rate_q;
  assign distance_half = 8'(total_q >> STEPS_PER_HALF_MILE_SHIFT);
  assign active_secs   = active_q;
  assign disp_sel      = disp_sel_q;
  assign state         = state_q;

endmodule
